// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the write port and the registered read port of the dual-address
//   register-file RAM between two requesters. Each port has its own
//   round-robin arbiter. In-flight reads are tracked by a 2-stage tag
//   pipeline that lines up with the RAM's 2-cycle read latency, so every
//   returning word is steered to the requester that issued it.
//
//   Optional build macro: RAM_ARB_STATS_EN adds the conflict_cnt and
//   grant_cnt saturating statistics counters.
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   req_valid[1:0]  per-requester op valid
//   req_we[1:0]     per-requester op type (1 = write, 0 = read)
//   req_addr        requester i address at [i*ADDR_SIZE +: ADDR_SIZE]
//   req_data        requester i write data at [i*REG_SIZE +: REG_SIZE]
//   req_ready[1:0]  grant; op transfers when req_valid[i] & req_ready[i]
//   rsp_valid[1:0]  read data valid for requester i
//   rsp_data        read data shared by both requesters (ram_q passthrough)
//   ram_we, ram_a_in, ram_d   RAM write port
//   ram_a_out       RAM read address
//   ram_q           RAM read data
//   conflict_cnt    (RAM_ARB_STATS_EN) cycles/ports with two contenders
//   grant_cnt       (RAM_ARB_STATS_EN) accepted ops, requester i at [i*16 +: 16]
module ram_port_arbiter #(
  parameter int REG_SIZE  = 36,
  parameter int ADDR_SIZE = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_SIZE-1:0]  req_addr,
  input  logic [2*REG_SIZE-1:0]   req_data,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [REG_SIZE-1:0]     rsp_data,
  output logic                    ram_we,
  output logic [ADDR_SIZE-1:0]    ram_a_in,
  output logic [REG_SIZE-1:0]     ram_d,
  output logic [ADDR_SIZE-1:0]    ram_a_out,
  input  logic [REG_SIZE-1:0]     ram_q
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]             conflict_cnt,
  output logic [31:0]             grant_cnt
`endif
);

  logic       wr_last, rd_last;
  logic [1:0] want_wr, want_rd;
  logic [1:0] gnt_wr, gnt_rd;
  logic       wr_sel, rd_sel;
  logic       v_p1, t_p1, v_p2, t_p2;

  // Contenders are masked while reset is held so nothing is granted.
  always_comb begin
    want_wr = rst ? 2'b00 : (req_valid & req_we);
    want_rd = rst ? 2'b00 : (req_valid & ~req_we);
    // Single contender: its index is simply bit 1 of the request mask.
    wr_sel  = (want_wr == 2'b11) ? ~wr_last : want_wr[1];
    rd_sel  = (want_rd == 2'b11) ? ~rd_last : want_rd[1];
    gnt_wr  = 2'b00;
    gnt_rd  = 2'b00;
    if (|want_wr) gnt_wr[wr_sel] = 1'b1;
    if (|want_rd) gnt_rd[rd_sel] = 1'b1;
  end

  assign req_ready = gnt_wr | gnt_rd;
  assign ram_we    = |gnt_wr;
  assign ram_a_in  = !ram_we ? '0 :
                     (wr_sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0]);
  assign ram_d     = !ram_we ? '0 :
                     (wr_sel ? req_data[2*REG_SIZE-1:REG_SIZE] : req_data[REG_SIZE-1:0]);
  assign ram_a_out = !(|gnt_rd) ? '0 :
                     (rd_sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0]);

  // Round-robin state and read-valid pipeline (control, reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_last <= 1'b1;
      rd_last <= 1'b1;
      v_p1    <= 1'b0;
      v_p2    <= 1'b0;
    end else begin
      if (|want_wr) wr_last <= wr_sel;
      if (|want_rd) rd_last <= rd_sel;
      // Stage 1: read issued to the RAM this edge
      v_p1 <= |want_rd;
      // Stage 2: RAM q now holds that read's word
      v_p2 <= v_p1;
    end
  end

  // Tag pipeline (data, qualified by the valids above).
  always_ff @(posedge clk) begin
    t_p1 <= rd_sel;
    t_p2 <= t_p1;
  end

  assign rsp_valid = {v_p2 & t_p2, v_p2 & ~t_p2};
  assign rsp_data  = ram_q;

`ifdef RAM_ARB_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0] conflict_inc;
  assign conflict_inc = {1'b0, &want_wr} + {1'b0, &want_rd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
      grant_cnt    <= '0;
    end else begin
      conflict_cnt      <= sat_add(conflict_cnt, conflict_inc);
      grant_cnt[15:0]   <= sat_add(grant_cnt[15:0],  {1'b0, req_ready[0]});
      grant_cnt[31:16]  <= sat_add(grant_cnt[31:16], {1'b0, req_ready[1]});
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Self-checking bench for ram_port_arbiter. Contains a behavioural model of
//   the register-file RAM (registered read address, registered q) and a
//   reference model of the arbitration rules: per-port round robin, a shadow
//   memory and a per-cycle schedule of expected responses.
module tb_ram_port_arbiter;
  localparam int RS = 36;
  localparam int AS = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_we;
  logic [2*AS-1:0] req_addr;
  logic [2*RS-1:0] req_data;
  logic [1:0]      req_ready, rsp_valid;
  logic [RS-1:0]   rsp_data, ram_d, ram_q;
  logic            ram_we;
  logic [AS-1:0]   ram_a_in, ram_a_out;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]     conflict_cnt;
  logic [31:0]     grant_cnt;
`endif

  ram_port_arbiter #(.REG_SIZE(RS), .ADDR_SIZE(AS)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_we(ram_we),
    .ram_a_in(ram_a_in), .ram_d(ram_d), .ram_a_out(ram_a_out), .ram_q(ram_q)
`ifdef RAM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // RAM: write at the edge, read address registered, then q registered.
  logic          clr;
  logic [RS-1:0] ram_mem [32];
  logic [AS-1:0] ra_q;
  logic [RS-1:0] q_r;
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 32; k++) ram_mem[k] <= '0;
      ra_q <= '0;
      q_r  <= '0;
    end else begin
      if (ram_we) ram_mem[ram_a_in] <= ram_d;
      ra_q <= ram_a_out;
      q_r  <= ram_mem[ra_q];
    end
  end
  assign ram_q = q_r;

  // Reference model state.
  int            n_vec = 0, n_err = 0, cyc = 0;
  int            wr_last_m, rd_last_m;
  logic [RS-1:0] sh_mem [32];
  logic [1:0]    exp_v [0:4095];
  logic [RS-1:0] exp_d [0:4095];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Winner of one port given its contender mask, or -1 when nobody asks.
  function automatic int pick(input logic [1:0] m, input int last);
    case (m)
      2'b01:   return 0;
      2'b10:   return 1;
      2'b11:   return 1 - last;
      default: return -1;
    endcase
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, advance.
  task automatic step(input logic [1:0] v, input logic [1:0] we,
                      input logic [AS-1:0] a0, input logic [AS-1:0] a1,
                      input logic [RS-1:0] d0, input logic [RS-1:0] d1);
    int ww, rw;
    logic [1:0] er;
    logic [AS-1:0] wa, ra;
    req_valid = v; req_we = we; req_addr = {a1, a0}; req_data = {d1, d0};
    #1;
    chk("rsp_valid", rsp_valid, exp_v[cyc]);
    if (exp_v[cyc] != 2'b00) chk("rsp_data", rsp_data, exp_d[cyc]);
    ww = pick(v & we, wr_last_m);
    rw = pick(v & ~we, rd_last_m);
    er = 2'b00;
    if (ww >= 0) er[ww] = 1'b1;
    if (rw >= 0) er[rw] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("ram_we", ram_we, ww >= 0);
    if (ww >= 0) begin
      wa = (ww == 1) ? a1 : a0;
      chk("ram_a_in", ram_a_in, wa);
      chk("ram_d", ram_d, (ww == 1) ? d1 : d0);
      sh_mem[wa] = (ww == 1) ? d1 : d0;
      wr_last_m = ww;
    end
    if (rw >= 0) begin
      ra = (rw == 1) ? a1 : a0;
      chk("ram_a_out", ram_a_out, ra);
      exp_v[cyc+2] = (rw == 1) ? 2'b10 : 2'b01;
      exp_d[cyc+2] = sh_mem[ra];
      rd_last_m = rw;
    end else begin
      chk("ram_a_out_idle", ram_a_out, 0);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0);
  endtask

  // Reset pulse inside one cycle with both requesters asking.
  task automatic rst_pulse();
    req_valid = 2'b11; req_we = 2'b01; req_addr = {5'd9, 5'd9}; req_data = '1;
    rst = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_ram_a_in", ram_a_in, 0);
    chk("rst_ram_d", ram_d, 0);
    chk("rst_ram_a_out", ram_a_out, 0);
    req_valid = 2'b00; req_we = 2'b00;
    #1;
    rst = 1'b0;
    wr_last_m = 1;
    rd_last_m = 1;
    for (int k = cyc; k < cyc + 4; k++) exp_v[k] = 2'b00;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    logic [63:0] r0, r1;
    logic [1:0]  rv, rwe;
`ifdef RAM_ARB_STATS_EN
    logic [15:0] cc0;
    logic [31:0] gc0;
`endif
    rst = 1'b1; clr = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_data = '0;
    for (int k = 0; k < 32; k++) sh_mem[k] = '0;
    for (int k = 0; k < 4096; k++) begin exp_v[k] = 2'b00; exp_d[k] = '0; end
    repeat (2) @(posedge clk);
    clr = 1'b0;
    #1;
    rst_pulse();
    idle(1);

    // Write then read of the same address.
    step(2'b01, 2'b01, 5'd3, 5'd0, 36'h123456789, '0);
    step(2'b01, 2'b00, 5'd3, 5'd0, '0, '0);
    idle(3);

    // Cross ops: req0 writes addr 7 while req1 reads addr 7.
    step(2'b11, 2'b01, 5'd7, 5'd7, 36'd5, '0);
    idle(3);

    // Write conflict on addr 4, then read it back.
    step(2'b11, 2'b11, 5'd4, 5'd4, 36'd1, 36'd2);
    step(2'b11, 2'b11, 5'd4, 5'd4, 36'd1, 36'd2);
    step(2'b01, 2'b00, 5'd4, 5'd0, '0, '0);
    idle(3);

    // Distinct contents for addresses 1 and 2.
    step(2'b01, 2'b01, 5'd1, 5'd0, 36'hA_AAAA_0001, '0);
    step(2'b10, 2'b10, 5'd0, 5'd2, '0, 36'h5_5555_0002);
    idle(1);

    // Reads accepted on two edges, then reset pulses in the following cycle.
    step(2'b01, 2'b00, 5'd1, 5'd0, '0, '0);
    step(2'b10, 2'b00, 5'd0, 5'd2, '0, '0);
    rst_pulse();
    idle(3);

    // Read conflict for 6 cycles; first conflict after reset goes to req0.
`ifdef RAM_ARB_STATS_EN
    cc0 = conflict_cnt;
    gc0 = grant_cnt;
`endif
    for (int i = 0; i < 6; i++) step(2'b11, 2'b00, 5'd1, 5'd2, '0, '0);
`ifdef RAM_ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt - cc0, 6);
    chk("grant_cnt0", grant_cnt[15:0] - gc0[15:0], 3);
    chk("grant_cnt1", grant_cnt[31:16] - gc0[31:16], 3);
`endif
    idle(3);

    // Randomized traffic over a small address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      r0 = {$urandom, $urandom};
      r1 = {$urandom, $urandom};
      rv  = 2'($urandom_range(0, 3));
      rwe = 2'($urandom_range(0, 3));
      step(rv, rwe, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           r0[RS-1:0], r1[RS-1:0]);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
